// File: rtl/button_debouncer.sv
// button_debouncer: multi-channel sync + prescaled saturating-count debouncer; define BUTTON_DEBOUNCER_BUSY_EN to add a per-channel busy output.
module button_debouncer #(
  parameter int WIDTH          = 1,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int PULSE_CNT_MAX  = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] glitchy_signal,
`ifdef BUTTON_DEBOUNCER_BUSY_EN
  output logic [WIDTH-1:0] busy,
`endif
  output logic [WIDTH-1:0] debounced_signal
);
  localparam int SW = SAMPLE_CNT_MAX > 1 ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int PW = PULSE_CNT_MAX > 1 ? $clog2(PULSE_CNT_MAX) : 1;
  logic [WIDTH-1:0] sync1_q, sync2_q, debounced_q, debounced_d;
  logic [SW-1:0]    pre_q, pre_d;
  logic [PW-1:0]    cnt_q [WIDTH];
  logic [PW-1:0]    cnt_d [WIDTH];
  logic             sample_tick;
  assign sample_tick = pre_q == SW'(SAMPLE_CNT_MAX - 1);
  assign pre_d       = sample_tick ? '0 : pre_q + SW'(1);
  // a matching sample or a completed run both clear the counter
  always_comb begin
    debounced_d = debounced_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = !sample_tick ? cnt_q[i] :
                 (sync2_q[i] == debounced_q[i] || cnt_q[i] == PW'(PULSE_CNT_MAX - 1)) ? '0 :
                 cnt_q[i] + PW'(1);
      debounced_d[i] = (sample_tick && sync2_q[i] != debounced_q[i] &&
                        cnt_q[i] == PW'(PULSE_CNT_MAX - 1)) ? sync2_q[i] : debounced_q[i];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      pre_q       <= '0;
      cnt_q       <= '{default: '0};
      debounced_q <= '0;
    end else begin
      sync1_q     <= glitchy_signal;
      sync2_q     <= sync1_q;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      debounced_q <= debounced_d;
    end
  end
  assign debounced_signal = debounced_q;
`ifdef BUTTON_DEBOUNCER_BUSY_EN
  always_comb begin
    busy = '0;
    for (int i = 0; i < WIDTH; i++) busy[i] = cnt_q[i] != '0;
  end
`endif
endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Multi-channel debouncer for raw mechanical pushbutton/switch inputs.
- Sits directly upstream of the edge detector. Its debounced, glitch-free levels drive the edge detector's signal_in, which turns each press into a single-cycle pulse for the counter.
- Includes its own 2-flop input synchronizer and a shared sample-rate prescaler.
- Each channel changes state only after its input holds the opposite level for a programmable number of consecutive samples.

Parameters:
- WIDTH, 1, number of independent button channels.
- SAMPLE_CNT_MAX, 62500, prescaler period in clk cycles between sample ticks. Must be >= 1. Default gives 0.5 ms at 125 MHz.
- PULSE_CNT_MAX, 200, consecutive mismatching samples required to flip an output. Must be >= 1. Default gives 100 ms.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- glitchy_signal  input  WIDTH  raw asynchronous button levels, one bit per channel.
- debounced_signal  output  WIDTH  registered, debounced levels, one bit per channel.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - While rst_n=0, all flops clear immediately, independent of clk: sync stages, prescaler, per-channel counters, debounced_signal.
  - debounced_signal resets to all 0.
  - Release is sampled on the next clk rising edge.
  - Reset asserted mid-count discards all partial progress.
- Synchronizer: glitchy_signal passes through two flop stages (sync1, sync2), 2 cycles of latency. Only sync2 feeds the debounce logic.
- Prescaler: one shared counter, width $clog2(SAMPLE_CNT_MAX) (min 1 bit), reset value 0.
  - Counts 0..SAMPLE_CNT_MAX-1, then wraps to 0.
  - sample_tick is internal and combinational: high while count == SAMPLE_CNT_MAX-1.
  - When SAMPLE_CNT_MAX=1, sample_tick is permanently high.
- Per-channel saturating counter, width $clog2(PULSE_CNT_MAX) (min 1 bit), reset value 0. Acts only on an edge where sample_tick=1; otherwise counter and output hold.
  - sync2[i] == debounced_signal[i]: cnt[i] <= 0.
  - sync2[i] != debounced_signal[i] and cnt[i] < PULSE_CNT_MAX-1: cnt[i] <= cnt[i]+1.
  - sync2[i] != debounced_signal[i] and cnt[i] == PULSE_CNT_MAX-1: debounced_signal[i] <= sync2[i] and cnt[i] <= 0, on the same edge.
- Symmetric filter: press (0->1) and release (1->0) have identical qualification.
- Any single matching sample during a run restarts the run.
- Glitches between sample ticks are invisible.
- Latency from a clean input step to the output flip:
  - 2 cycles (synchronizer), plus
  - up to SAMPLE_CNT_MAX-1 cycles (prescaler phase), plus
  - (PULSE_CNT_MAX-1)*SAMPLE_CNT_MAX cycles, plus
  - 1 cycle.
- Channels are fully independent. Simultaneous flips on several channels occur on the same tick edge.
- debounced_signal is driven directly from flops, with no combinational path from glitchy_signal.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_BUSY_EN.
- Defined: adds output port busy (WIDTH). busy[i] = (cnt[i] != 0), combinational from the counter flops. It flags a channel that is mid-qualification, for LEDs and debug. It is 0 during and after reset.
- Undefined: no busy port. The behaviour of debounced_signal is identical in both builds.

Test Plan (SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, WIDTH=2; edge 1 = first clk edge after rst_n rises):
- Reset: hold glitchy_signal=2'b11 with rst_n=0 -> debounced_signal=2'b00 throughout. Drive rst_n=0 asynchronously mid-cycle after the output is high -> output clears before the next clk edge.
- Clean press: glitchy_signal=2'b01, held from reset release -> bit0 rises exactly at edge 12 (ticks at edges 4, 8, 12); bit1 stays 0.
- Bounce reject: after a clean press, drive ch0 low for exactly 2 consecutive tick samples, then high -> debounced_signal[0] stays 1, cnt returns to 0.
- Clean release: after a clean press, hold ch0=0 -> bit0 falls on the 3rd sample tick after sync2 goes low.
- Sub-tick glitch: pulse ch1 high for 1 cycle between ticks, repeatedly -> debounced_signal[1] never rises.
- Busy (macro defined): during the clean-press scenario -> busy[0]=1 after edge 4 until edge 12, 0 after edge 12; busy[1]=0 throughout.
